// File: rtl/rmii_tx_arbiter_pkg.sv
// Shared definitions for the RMII TX arbiter slice.
// Covers the arbiter state encoding, byte width and the guard-gap helper.
package rmii_tx_arbiter_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned GAP_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // A zero-length guard gap still costs one cycle.
    function automatic int unsigned gap_len(input int unsigned cycles);
        return (cycles == 0) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/rmii_tx_arbiter_if.sv
// FWFT byte-FIFO read-side bundle with N lanes.
// The master modport drives data and flags; the slave modport drives pops.
interface rmii_tx_arbiter_if #(
    parameter int unsigned N = 1
);
    import rmii_tx_arbiter_pkg::*;

    logic [BYTE_W*N-1:0] dout;
    logic [N-1:0]        aempty;
    logic [N-1:0]        empty;
    logic [N-1:0]        EOD_out;
    logic [N-1:0]        rden;

    modport master (output dout, aempty, empty, EOD_out, input rden);
    modport slave  (input dout, aempty, empty, EOD_out, output rden);

endinterface

// File: rtl/rmii_tx_arbiter_rr_pick.sv
// Combinational round-robin finder.
// Returns the first eligible index at or above rr_ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     pick,
    output logic             valid
);
    logic [PTR_W-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PTR_W'((32'(rr_ptr) + k) % N);
            if (!valid && eligible[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rmii_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one RMII_TX FIFO port among N_REQ sources.
// The grant is held until the owner's EOD byte is popped, followed by a guard gap.
module rmii_tx_arbiter
    import rmii_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                   REF_CLK,
    input  logic                   srst,
    rmii_tx_arbiter_if.slave       s_fifo,
    rmii_tx_arbiter_if.master      m_fifo,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [CNT_W*N_REQ-1:0] frame_cnt
);
    localparam int unsigned      PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned      GAP_LEN  = gap_len(GAP_CYCLES);
    localparam int unsigned      GAP_W    = $clog2(GAP_LEN + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_LEN - 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    arb_state_t       state, state_nx;
    logic [PTR_W-1:0] g_idx;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pick_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] cnt [N_REQ];
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] pick;
    logic             pick_valid;
    logic             frame_end;

    assign eligible = ~s_fifo.aempty & ~s_fifo.empty;

    rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .valid    (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    assign frame_end = (state == ST_GRANT) & m_fifo.rden[0]
                     & ~s_fifo.empty[g_idx] & s_fifo.EOD_out[g_idx];

    always_ff @(posedge REF_CLK) begin
        if (srst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (pick_valid) state_nx = ST_GRANT;
            ST_GRANT: if (frame_end) state_nx = ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Grant stays visible through the gap so debug shows the last owner.
    always_ff @(posedge REF_CLK) begin
        if (srst) begin
            grant   <= '0;
            g_idx   <= '0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick;
                        g_idx <= pick_idx;
                    end
                end
                ST_GRANT: begin
                    if (frame_end) begin
                        gap_cnt    <= GAP_LOAD;
                        cnt[g_idx] <= cnt[g_idx] + CNT_W'(1);
                        rr_ptr     <= (g_idx == LAST_IDX) ? '0 : g_idx + PTR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) grant <= '0;
                    else               gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: grant <= '0;
            endcase
        end
    end

    always_comb begin
        s_fifo.rden    = '0;
        m_fifo.dout    = '0;
        m_fifo.aempty  = '1;
        m_fifo.empty   = '1;
        m_fifo.EOD_out = '0;
        if (state == ST_GRANT && !srst) begin
            m_fifo.dout       = s_fifo.dout[32'(g_idx)*BYTE_W +: BYTE_W];
            m_fifo.aempty[0]  = s_fifo.aempty[g_idx];
            m_fifo.empty[0]   = s_fifo.empty[g_idx];
            m_fifo.EOD_out[0] = s_fifo.EOD_out[g_idx];
            s_fifo.rden[g_idx] = m_fifo.rden[0] & ~s_fifo.empty[g_idx];
        end
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        frame_cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) frame_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule

// File: tb/tb_rmii_tx_arbiter.sv
// Self-checking bench for rmii_tx_arbiter: per-cycle compare against an owner/gap model,
// plus directed scenarios and a second instance with a zero gap and a narrow frame counter.
module tb_rmii_tx_arbiter;
    import rmii_tx_arbiter_pkg::*;

    localparam int GAP = 4;

    logic clk = 1'b0;
    always #10 clk = ~clk;
    logic srst;

    rmii_tx_arbiter_if #(.N(2)) src ();
    rmii_tx_arbiter_if #(.N(1)) snk ();
    logic [1:0]  grant;
    logic        busy;
    logic [31:0] frame_cnt;

    rmii_tx_arbiter #(.N_REQ(2), .GAP_CYCLES(4), .CNT_W(16)) dut (
        .REF_CLK(clk), .srst(srst), .s_fifo(src.slave), .m_fifo(snk.master),
        .grant(grant), .busy(busy), .frame_cnt(frame_cnt)
    );

    rmii_tx_arbiter_if #(.N(2)) src2 ();
    rmii_tx_arbiter_if #(.N(1)) snk2 ();
    logic [1:0] grant2;
    logic       busy2;
    logic [7:0] frame_cnt2;

    rmii_tx_arbiter #(.N_REQ(2), .GAP_CYCLES(0), .CNT_W(4)) dut2 (
        .REF_CLK(clk), .srst(srst), .s_fifo(src2.slave), .m_fifo(snk2.master),
        .grant(grant2), .busy(busy2), .frame_cnt(frame_cnt2)
    );

    int checks = 0, failures = 0, cyc = 0;
    logic [8:0] q0[$], q1[$], q2[$];
    bit hold [2];
    bit rand_rden = 1'b0, rand_hold = 1'b0;
    // Model: owner of the port (-1 none), remaining gap cycles, next search start, frames done.
    int owner = -1, gap_left = 0, ptr = 0;
    int frames [2];
    int grant_log[$];
    logic [7:0] sink[$];
    int eod_cyc = -100, zero_cyc = -100;
    logic [1:0] prev_grant = 2'b00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [8:0] qhead(input int i);
        if (i == 0 && q0.size() > 0) return q0[0];
        if (i == 1 && q1.size() > 0) return q1[0];
        return 9'h000;
    endfunction

    task automatic pop(input int i);
        if (i == 0 && q0.size() > 0) void'(q0.pop_front());
        if (i == 1 && q1.size() > 0) void'(q1.pop_front());
    endtask

    task automatic push_frame(input int s, input logic [7:0] first, input int len, input bit rnd);
        for (int k = 0; k < len; k++) begin
            logic [8:0] e;
            e[7:0] = rnd ? 8'($urandom) : first + 8'(k);
            e[8]   = (k == len - 1);
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            int n;
            logic [8:0] h;
            n = hold[i] ? 0 : qsize(i);
            h = qhead(i);
            src.dout[8*i +: 8] = (n > 0) ? h[7:0] : 8'h00;
            src.EOD_out[i]     = (n > 0) && h[8];
            src.empty[i]       = (n == 0);
            src.aempty[i]      = (n < 2);
        end
    endtask

    task automatic drive2();
        logic [8:0] h;
        h = (q2.size() > 0) ? q2[0] : 9'h000;
        src2.dout        = {8'h00, h[7:0]};
        src2.EOD_out     = {1'b0, (q2.size() > 0) && h[8]};
        src2.empty       = {1'b1, q2.size() == 0};
        src2.aempty      = {1'b1, q2.size() < 2};
    endtask

    task automatic step();
        logic [7:0] exp_dout;
        logic       exp_ae, exp_e, exp_eod;
        logic [1:0] exp_rd, exp_gr;
        bit         serving;
        @(negedge clk);
        cyc++;
        if (srst) begin
            owner = -1; gap_left = 0; ptr = 0; frames[0] = 0; frames[1] = 0;
        end else begin
            serving  = (owner >= 0) && (gap_left == 0);
            exp_dout = 8'h00; exp_ae = 1'b1; exp_e = 1'b1; exp_eod = 1'b0; exp_rd = 2'b00;
            if (serving) begin
                exp_dout       = src.dout[8*owner +: 8];
                exp_ae         = src.aempty[owner];
                exp_e          = src.empty[owner];
                exp_eod        = src.EOD_out[owner];
                exp_rd[owner]  = snk.rden[0] & ~src.empty[owner];
            end
            exp_gr = (owner >= 0) ? 2'(1 << owner) : 2'b00;
            check("m_fifo_dout", snk.dout, exp_dout);
            check("m_fifo_aempty", snk.aempty, exp_ae);
            check("m_fifo_empty", snk.empty, exp_e);
            check("m_fifo_EOD_out", snk.EOD_out, exp_eod);
            check("s_fifo_rden", src.rden, exp_rd);
            check("grant", grant, exp_gr);
            check("busy", busy, owner >= 0);
            check("frame_cnt", frame_cnt, {16'(frames[1]), 16'(frames[0])});
            if (serving) begin
                if (snk.rden[0] && !src.empty[owner] && src.EOD_out[owner]) begin
                    frames[owner]++;
                    gap_left = GAP;
                    ptr = (owner + 1) % 2;
                end
            end else if (owner >= 0) begin
                gap_left--;
                if (gap_left == 0) owner = -1;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    int i;
                    i = (ptr + k) % 2;
                    if (owner < 0 && !src.empty[i] && !src.aempty[i]) owner = i;
                end
                if (owner >= 0) grant_log.push_back(owner);
            end
        end
        if (|(src.rden & src.EOD_out)) eod_cyc = cyc;
        if (prev_grant != 2'b00 && grant == 2'b00) zero_cyc = cyc;
        prev_grant = grant;
        if (snk.rden[0] && !snk.empty[0]) sink.push_back(snk.dout);
        for (int i = 0; i < 2; i++) if (src.rden[i]) pop(i);
        @(posedge clk);
        #1;
        if (rand_hold) begin
            hold[0] = ($urandom_range(0, 7) == 0);
            hold[1] = ($urandom_range(0, 7) == 0);
        end
        if (rand_rden) snk.rden[0] = ($urandom_range(0, 3) != 0);
        drive();
    endtask

    task automatic run_until_drained(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || owner >= 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_within_budget", n < budget, 1'b1);
        repeat (3) step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, grant, 2'b00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_cnt"}, frame_cnt, 32'h0);
        check({tag, "_m_empty"}, snk.empty, 1'b1);
        check({tag, "_m_aempty"}, snk.aempty, 1'b1);
        check({tag, "_m_dout"}, snk.dout, 8'h00);
        check({tag, "_m_eod"}, snk.EOD_out, 1'b0);
        check({tag, "_s_rden"}, src.rden, 2'b00);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        step();
        srst = 1'b0;
        #1;
        check_idle_outputs("rst");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, eods, e_cyc;
        logic [1:0] pg;
        hold[0] = 1'b0; hold[1] = 1'b0;
        frames[0] = 0; frames[1] = 0;
        snk.rden = 1'b0;
        snk2.rden = 1'b0;
        srst = 1'b1;
        drive();
        drive2();
        step();
        do_reset();

        // Single source: 0x09..0x1F, gap of GAP cycles before grant clears.
        snk.rden = 1'b1;
        sink.delete();
        push_frame(0, 8'h09, 23, 1'b0);
        run_until_drained(200);
        check("t1_bytes", sink.size(), 23);
        for (int k = 0; k < sink.size() && k < 23; k++) check("t1_byte", sink[k], 8'h09 + 8'(k));
        check("t1_frame_cnt0", frame_cnt[15:0], 16'd1);
        // EOD pop happens at the end of the sampled cycle, so grant reads 0 GAP+1 samples later.
        check("t1_gap_len", zero_cyc - eod_cyc, GAP + 1);

        // Contention: both eligible together after reset, source 0 first, no interleave.
        do_reset();
        sink.delete(); grant_log.delete();
        push_frame(0, 8'hA0, 8, 1'b0);
        push_frame(1, 8'hB0, 8, 1'b0);
        run_until_drained(200);
        check("t2_bytes", sink.size(), 16);
        for (int k = 0; k < sink.size() && k < 16; k++)
            check("t2_byte", sink[k], (k < 8) ? 8'hA0 + 8'(k) : 8'hB0 + 8'(k - 8));
        check("t2_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t2_first_grant", grant_log[0], 0);
            check("t2_second_grant", grant_log[1], 1);
        end

        // Fairness: six frames, three per source, random lengths and sink pacing.
        do_reset();
        grant_log.delete();
        rand_rden = 1'b1;
        for (int f = 0; f < 3; f++) begin
            push_frame(0, 8'h00, $urandom_range(2, 7), 1'b1);
            push_frame(1, 8'h00, $urandom_range(2, 7), 1'b1);
        end
        run_until_drained(600);
        rand_rden = 1'b0;
        check("t3_grants", grant_log.size(), 6);
        for (int k = 0; k < grant_log.size() && k < 6; k++) check("t3_grant_order", grant_log[k], k % 2);
        check("t3_frame_cnt", frame_cnt, {16'd3, 16'd3});

        // Underrun: source 0 empty for 5 cycles mid-frame, source 1 waits.
        do_reset();
        snk.rden = 1'b1;
        sink.delete(); grant_log.delete();
        push_frame(0, 8'h40, 12, 1'b0);
        push_frame(1, 8'h50, 6, 1'b0);
        n = 0;
        while (q0.size() > 8 && n < 100) begin step(); n++; end
        check("t4_reach_mid", n < 100, 1'b1);
        hold[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            check("t4_hold_grant", grant, 2'b01);
            check("t4_hold_rden", src.rden, 2'b00);
        end
        hold[0] = 1'b0;
        run_until_drained(200);
        check("t4_bytes", sink.size(), 18);
        if (sink.size() == 18) begin
            check("t4_last_a", sink[11], 8'h4B);
            check("t4_first_b", sink[12], 8'h50);
        end
        check("t4_frame_cnt", frame_cnt, {16'd1, 16'd1});

        // Reset at byte 10 of a frame; upstream flushes the remainder.
        push_frame(0, 8'h60, 20, 1'b0);
        n = 0;
        while (q0.size() > 10 && n < 100) begin step(); n++; end
        check("t5_reach_mid", n < 100, 1'b1);
        check("t5_busy_before", busy, 1'b1);
        srst = 1'b1;
        q0.delete();
        step();
        srst = 1'b0;
        #1;
        check_idle_outputs("t5");

        // Random traffic with random pacing and intermittent source stalls.
        rand_rden = 1'b1;
        rand_hold = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int f = 0; f < int'($urandom_range(1, 2)); f++) push_frame(0, 8'h00, $urandom_range(2, 9), 1'b1);
            for (int f = 0; f < int'($urandom_range(0, 2)); f++) push_frame(1, 8'h00, $urandom_range(2, 9), 1'b1);
            run_until_drained(1500);
        end
        rand_hold = 1'b0; rand_rden = 1'b0;
        hold[0] = 1'b0; hold[1] = 1'b0;

        // Zero guard gap and 4-bit counter wrap on the second instance.
        snk2.rden = 1'b1;
        for (int f = 0; f < 17; f++)
            for (int k = 0; k < 3; k++) q2.push_back({k == 2, 8'(f * 3 + k)});
        drive2();
        n = 0; eods = 0; e_cyc = -100; pg = 2'b00;
        while ((q2.size() != 0 || busy2) && n < 1000) begin
            @(negedge clk);
            n++;
            if (n == e_cyc + 1) check("gap0_m_empty", snk2.empty, 1'b1);
            if (pg != 2'b00 && grant2 == 2'b00) check("gap0_len", n - e_cyc, 2);
            if (src2.rden[0] && src2.EOD_out[0]) begin eods++; e_cyc = n; end
            pg = grant2;
            if (src2.rden[0] && q2.size() > 0) void'(q2.pop_front());
            @(posedge clk);
            #1;
            drive2();
        end
        check("gap0_done", n < 1000, 1'b1);
        check("gap0_frames", eods, 17);
        check("gap0_cnt_wrap", frame_cnt2[3:0], 4'd1);
        check("gap0_cnt_src1", frame_cnt2[7:4], 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
